sadd_pipe_sat: RTL and testbench

Parametrised signed adder/subtractor, WIDTH bits, with a 2-stage valid/ready pipeline. Detects signed overflow, with optional saturation, running accumulation and a sticky overflow flag. Generational successor to the 8-bit combinational signed adder with overflow. Sits between operand producers and result consumers in the datapath and tolerates backpressure.

---
 rtl/sadd_pipe_sat.sv | 172 +++++++++++++++++
 tb/tb_sadd_pipe_sat.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sadd_pipe_sat.sv
// Two-stage valid/ready signed adder/subtractor with overflow detection,
// optional saturation, a running accumulator and a sticky overflow flag.
module sadd_pipe_sat #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    input  logic             sat_mode,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic             ovf_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             ovf_sticky
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic             r_s1_sub;
    logic             r_s1_sat;
    logic             r_s1_acc;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_sticky;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_a_eff;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [WIDTH:0]   w_raw;
    logic             w_carry_msb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum;

    // Clamp toward the sign of A: two operands of equal sign can only overflow away from zero.
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] raw,
        input logic             sat,
        input logic             ovf,
        input logic             a_sign
    );
        logic [WIDTH-1:0] res;
        res = raw;
        if (sat && ovf) begin
            if (a_sign) begin
                res = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            res = raw;
        end
        return res;
    endfunction

    assign in_ready   = !r_s1_valid || !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);

    assign out_valid  = r_out_valid;
    assign sum        = r_sum;
    assign carry_out  = r_carry;
    assign overflow   = r_ovf;
    assign ovf_sticky = r_sticky;

    always_comb begin
        w_a_eff     = '0;
        w_b_eff     = '0;
        w_cin_eff   = 1'b0;
        if (r_s1_acc) begin
            w_a_eff = r_acc;
        end else begin
            w_a_eff = r_s1_a;
        end
        if (r_s1_sub) begin
            w_b_eff   = ~r_s1_b;
            w_cin_eff = ~r_s1_cin;
        end else begin
            w_b_eff   = r_s1_b;
            w_cin_eff = r_s1_cin;
        end
        w_raw       = {1'b0, w_a_eff} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
        w_carry_msb = w_a_eff[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_raw[WIDTH-1];
        w_ovf       = w_carry_msb ^ w_raw[WIDTH];
        w_sum       = saturate(w_raw[WIDTH-1:0], r_s1_sat, w_ovf, w_a_eff[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_s1_sat   <= 1'b0;
            r_s1_acc   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_cin   <= c_in;
            r_s1_sub   <= op_sub;
            r_s1_sat   <= sat_mode;
            r_s1_acc   <= acc_mode;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Result registers hold while the consumer stalls; out_valid drops once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_sum;
            r_carry     <= w_raw[WIDTH];
            r_ovf       <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_s2_load) begin
            r_acc <= w_sum;
        end else begin
            r_acc <= r_acc;
        end
    end

    // A new overflow outranks a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_s2_load && w_ovf) begin
            r_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= r_sticky;
        end
    end

endmodule

// File: tb/tb_sadd_pipe_sat.sv
// Scoreboard bench for sadd_pipe_sat at WIDTH=8: an arithmetic model pushes
// expected results on accept, a monitor pops and compares on output handshake.
module tb_sadd_pipe_sat;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         op_sub;
    logic         sat_mode;
    logic         acc_mode;
    logic         acc_clr;
    logic         ovf_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         ovf_sticky;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           cyc;
        logic         lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   model_acc = 0;
    logic lat_en   = 1'b1;

    sadd_pipe_sat #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op_sub    (op_sub),
        .sat_mode  (sat_mode),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Mathematical reference: signed range test for overflow, unsigned compare for carry.
    task automatic model(input int av, input int bv, input int ci, input logic sub,
                         input logic sat, output logic [W-1:0] s, output logic co,
                         output logic ov);
        int ideal;
        int ua;
        int ub;
        ideal = sub ? (av - bv - ci) : (av + bv + ci);
        ua    = (av < 0) ? av + 256 : av;
        ub    = (bv < 0) ? bv + 256 : bv;
        co    = sub ? (ua >= ub + ci) : (ua + ub + ci >= 256);
        ov    = (ideal > 127) || (ideal < -128);
        if (sat && ov) begin
            ideal = (ideal > 127) ? 127 : -128;
        end
        s = ideal[W-1:0];
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic tsub, input logic tsat, input logic tacc);
        logic         rdy;
        int           cyc_a;
        bit           done;
        exp_t         e;
        int           av;
        done     = 1'b0;
        a        = ta;
        b        = tb;
        c_in     = tc;
        op_sub   = tsub;
        sat_mode = tsat;
        acc_mode = tacc;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy   = in_ready;
            cyc_a = cyc;
            @(posedge clk);
            #1;
            if (rdy) begin
                av = tacc ? model_acc : int'($signed(ta));
                model(av, int'($signed(tb)), int'(tc), tsub, tsat, e.s, e.co, e.ov);
                model_acc = int'($signed(e.s));
                e.cyc = cyc_a;
                e.lat = lat_en;
                q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 50 && !empty; i++) begin
            @(posedge clk);
            #1;
            empty = (q.size() == 0) && !out_valid;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("carry_out", 64'(carry_out), 64'(e.co));
                chk("overflow", 64'(overflow), 64'(e.ov));
                if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;
        sat_mode = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
        chk("rst_co_ov", 64'({carry_out, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);

        for (int s = 0; s < 2; s++) begin
            send(8'd64, 8'd50, 1'b0, 1'b0, s[0], 1'b0);
            send(8'd120, 8'd10, 1'b0, 1'b0, s[0], 1'b0);
            send(8'hE2, 8'hBA, 1'b0, 1'b0, s[0], 1'b0);
            send(8'h9C, 8'hE2, 1'b0, 1'b0, s[0], 1'b0);
            drain();
            chk("sticky_after_ovf", 64'(ovf_sticky), 64'd1);
        end

        send(8'h80, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h80, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        send(8'd5, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'd5, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        for (int s = 1; s >= 0; s--) begin
            acc_clr = 1'b1;
            @(posedge clk);
            #1;
            acc_clr = 1'b0;
            model_acc = 0;
            for (int k = 0; k < 3; k++) send(8'd0, 8'd100, 1'b0, 1'b0, s[0], 1'b1);
            drain();
        end

        lat_en = 1'b0;
        out_ready = 1'b0;
        send(8'd64, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'd120, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        fork
            begin
                send(8'hE2, 8'hBA, 1'b0, 1'b0, 1'b0, 1'b0);
                send(8'h9C, 8'hE2, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_sum", 64'(sum), 64'd114);
                chk("bp_hold_ready", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        lat_en = 1'b1;

        send(8'd120, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'd64, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_sticky", 64'(ovf_sticky), 64'd0);
        q.delete();
        model_acc = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'd77, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        send(8'd120, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("sticky_cleared", 64'(ovf_sticky), 64'd0);
        send(8'd120, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
